spi_slave_accel_regif: RTL

SPI responder (slave) that terminates the 16-bit MPU9250-style register transactions issued by the accelerometer SPI master, decoding R/W + 7-bit address and serving a simple parallel register port. Used as the sensor-side model in system simulation and as the on-FPGA register target for loopback builds. All SPI inputs are oversampled and synchronized into `clk`; nothing is clocked by SCK.

---
 rtl/spi_slave_accel_regif.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_accel_regif.sv
// spi_slave_accel_regif: SPI mode-3 responder for 16-bit R/W + address + data
// register frames. SS, SCK and MOSI are oversampled into clk, and a parallel
// register port is driven from the decoded frame.
module spi_slave_accel_regif #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_SS_a,
  input  logic       SPI_CK_a,
  input  logic       SPI_DO_a,
  output logic       SPI_DI_a,
  output logic [6:0] reg_addr,
  output logic       reg_rd_req,
  input  logic [7:0] reg_rd_data,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD_FETCH,
    DATA_WR,
    DATA_RD,
    DONE
  } state_t;

  // The read byte is captured once the request pulse plus the port latency have elapsed.
  localparam logic [3:0] FETCH_LAST = 4'(RD_LATENCY + 1);

  logic [SYNC_STAGES-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0] ck_pipe;
  logic [SYNC_STAGES-1:0] do_pipe;
  logic                   ss_s;
  logic                   ck_s;
  logic                   do_s;
  logic                   ck_prev;
  logic                   ck_rise;
  logic                   ck_fall;

  state_t     state_q;
  state_t     state_d;
  logic       armed;
  logic [4:0] rise_cnt;
  logic       over_flag;
  logic [7:0] shift_q;
  logic [7:0] shift_next;
  logic [7:0] tx_q;
  logic [3:0] fetch_cnt;
  logic       fetch_done;
  logic       wr_pend;
  logic       di_bit;
  logic       di_q;

  // Synchronizer chains; SS resets low so a frame already running at reset
  // looks "not yet idle" and cannot be joined halfway through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_pipe <= '0;
      ck_pipe <= '1;
      do_pipe <= '0;
      ck_prev <= 1'b1;
    end else begin
      ss_pipe[0] <= SPI_SS_a;
      ck_pipe[0] <= SPI_CK_a;
      do_pipe[0] <= SPI_DO_a;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ss_pipe[i] <= ss_pipe[i-1];
        ck_pipe[i] <= ck_pipe[i-1];
        do_pipe[i] <= do_pipe[i-1];
      end
      ck_prev <= ck_s;
    end
  end

  assign ss_s       = ss_pipe[SYNC_STAGES-1];
  assign ck_s       = ck_pipe[SYNC_STAGES-1];
  assign do_s       = do_pipe[SYNC_STAGES-1];
  // Edges only count while SS is low, so an SS rise always beats a coincident edge.
  assign ck_rise    = !ss_s && ck_s && !ck_prev;
  assign ck_fall    = !ss_s && !ck_s && ck_prev;
  assign shift_next = {shift_q[6:0], do_s};
  assign fetch_done = (fetch_cnt == FETCH_LAST);
  assign busy       = armed && !ss_s;
  assign SPI_DI_a   = di_q;

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; any SS rise outside IDLE ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (armed && !ss_s) state_d = ADDR;
      end
      ADDR: begin
        if (ss_s) state_d = IDLE;
        else if (ck_rise && rise_cnt == 5'd7) state_d = shift_next[7] ? RD_FETCH : DATA_WR;
      end
      RD_FETCH: begin
        if (ss_s) state_d = IDLE;
        else if (fetch_done) state_d = DATA_RD;
      end
      DATA_WR, DATA_RD: begin
        if (ss_s) state_d = IDLE;
        else if (ck_rise && rise_cnt == 5'd15) state_d = DONE;
      end
      DONE: begin
        if (ss_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: rise counting, header/data shifting, register strobes and MISO shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed       <= 1'b0;
      rise_cnt    <= 5'd0;
      over_flag   <= 1'b0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      fetch_cnt   <= 4'd0;
      wr_pend     <= 1'b0;
      di_bit      <= 1'b0;
      di_q        <= 1'b0;
      reg_addr    <= 7'h00;
      reg_rd_req  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 8'h00;
      frame_err   <= 1'b0;
    end else begin
      reg_rd_req <= 1'b0;
      wr_pend    <= 1'b0;
      reg_wr_en  <= wr_pend;
      frame_err  <= 1'b0;
      di_q       <= (state_q == DATA_RD && !ss_s) ? di_bit : 1'b0;
      if (ss_s) armed <= 1'b1;

      if (state_q == IDLE) begin
        rise_cnt  <= 5'd0;
        over_flag <= 1'b0;
        fetch_cnt <= 4'd0;
        di_bit    <= 1'b0;
      end else if (ss_s) begin
        frame_err <= (rise_cnt != 5'd16) || over_flag;
      end else begin
        if (ck_rise) begin
          if (rise_cnt == 5'd16) begin
            over_flag <= 1'b1;
          end else begin
            rise_cnt <= rise_cnt + 5'd1;
            shift_q  <= shift_next;
          end
          if (rise_cnt == 5'd7) reg_addr <= shift_next[6:0];
          if (rise_cnt == 5'd15 && state_q == DATA_WR) begin
            reg_wr_data <= shift_next;
            wr_pend     <= 1'b1;
          end
        end
        if (state_q == RD_FETCH) begin
          fetch_cnt <= fetch_cnt + 4'd1;
          if (fetch_cnt == 4'd0) reg_rd_req <= 1'b1;
          if (fetch_done) tx_q <= reg_rd_data;
        end
        if (state_q == DATA_RD && ck_fall) begin
          di_bit <= tx_q[7];
          tx_q   <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end

endmodule
